// File: rtl/key_vol_ctrl_if.sv
// Codec configuration handshake between the key/volume controller and the
// I2C codec configuration master: one 16-bit word per req/ack exchange.
interface key_vol_ctrl_if;
  logic        Cfg_Req;
  logic [15:0] Cfg_Data;
  logic        Cfg_Ack;
  logic        Cfg_Err;

  modport master (
    output Cfg_Req,
    output Cfg_Data,
    output Cfg_Err,
    input  Cfg_Ack
  );

  modport slave (
    input  Cfg_Req,
    input  Cfg_Data,
    input  Cfg_Err,
    output Cfg_Ack
  );
endinterface

// File: rtl/key_vol_ctrl.sv
// Key-driven volume/mute controller. Latches one-cycle key flags into pending
// bits, applies saturating volume steps or a mute toggle, and sequences one
// codec register write at a time with ack timeout and an enforced idle gap.
module key_vol_ctrl #(
  parameter int         VOL_W       = 7,
  parameter int         VOL_MAX     = 127,
  parameter int         VOL_MIN     = 48,
  parameter int         VOL_DEF     = 121,
  parameter int         VOL_STEP    = 4,
  parameter logic [6:0] VOL_ADDR    = 7'h02,
  parameter logic [6:0] MUTE_ADDR   = 7'h05,
  parameter int         ACK_TIMEOUT = 1000000,
  parameter int         GAP_CYC     = 1000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Key_Up_Flag,
  input  logic                 Key_Dn_Flag,
  input  logic                 Key_Mute_Flag,
  key_vol_ctrl_if.master       cfg,
  output logic [VOL_W-1:0]     Volume,
  output logic                 Mute,
  output logic                 Busy
);

  // One counter serves both the ack timeout and the idle gap.
  localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

  // Saturation arithmetic runs one bit wider than the volume so it never wraps.
  localparam logic [VOL_W:0]   MAX_X  = (VOL_W + 1)'(VOL_MAX);
  localparam logic [VOL_W:0]   MIN_X  = (VOL_W + 1)'(VOL_MIN);
  localparam logic [VOL_W:0]   STEP_X = (VOL_W + 1)'(VOL_STEP);
  localparam logic [VOL_W-1:0] DEF_V  = VOL_W'(VOL_DEF);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    GAP      = 2'd2
  } state_t;

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [VOL_W-1:0]  vol_r;
  logic              mute_r;
  logic              pend_up_r;
  logic              pend_dn_r;
  logic              pend_mute_r;
  logic              req_r;
  logic [15:0]       data_r;
  logic              err_r;
  logic              busy_r;

  logic [VOL_W:0]    sum_s;
  logic [VOL_W:0]    diff_s;
  logic [VOL_W-1:0]  vol_up_s;
  logic [VOL_W-1:0]  vol_dn_s;

  // Next volume for an up or down step, clamped to [VOL_MIN, VOL_MAX].
  always_comb begin
    sum_s  = {1'b0, vol_r} + STEP_X;
    diff_s = {1'b0, vol_r} - STEP_X;
    if (sum_s > MAX_X) begin
      vol_up_s = MAX_X[VOL_W-1:0];
    end else begin
      vol_up_s = sum_s[VOL_W-1:0];
    end
    if ({1'b0, vol_r} < (MIN_X + STEP_X)) begin
      vol_dn_s = MIN_X[VOL_W-1:0];
    end else begin
      vol_dn_s = diff_s[VOL_W-1:0];
    end
  end

  // Write sequencer, volume/mute state and pending-event latches.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      vol_r       <= DEF_V;
      mute_r      <= 1'b0;
      pend_up_r   <= 1'b0;
      pend_dn_r   <= 1'b0;
      pend_mute_r <= 1'b0;
      req_r       <= 1'b0;
      data_r      <= 16'h0000;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pend_mute_r) begin
            mute_r      <= ~mute_r;
            data_r      <= {MUTE_ADDR, 8'h00, ~mute_r};
            pend_mute_r <= 1'b0;
            req_r       <= 1'b1;
            busy_r      <= 1'b1;
            cnt_r       <= '0;
            state_r     <= WAIT_ACK;
          end else if (pend_up_r && pend_dn_r) begin
            // Opposing presses cancel each other without a codec write.
            pend_up_r <= 1'b0;
            pend_dn_r <= 1'b0;
          end else if (pend_up_r) begin
            vol_r     <= vol_up_s;
            data_r    <= {VOL_ADDR, 9'(vol_up_s)};
            pend_up_r <= 1'b0;
            req_r     <= 1'b1;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            state_r   <= WAIT_ACK;
          end else if (pend_dn_r) begin
            vol_r     <= vol_dn_s;
            data_r    <= {VOL_ADDR, 9'(vol_dn_s)};
            pend_dn_r <= 1'b0;
            req_r     <= 1'b1;
            busy_r    <= 1'b1;
            cnt_r     <= '0;
            state_r   <= WAIT_ACK;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT_ACK: begin
          if (cfg.Cfg_Ack) begin
            req_r   <= 1'b0;
            cnt_r   <= '0;
            state_r <= GAP;
          end else if (cnt_r == TO_LAST) begin
            // Abandon the write; volume/mute keep their already-updated values.
            req_r   <= 1'b0;
            err_r   <= 1'b1;
            cnt_r   <= '0;
            state_r <= GAP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
      // A new flag wins over a same-cycle clear, and repeats coalesce.
      if (Key_Up_Flag) begin
        pend_up_r <= 1'b1;
      end
      if (Key_Dn_Flag) begin
        pend_dn_r <= 1'b1;
      end
      if (Key_Mute_Flag) begin
        pend_mute_r <= 1'b1;
      end
    end
  end

  assign cfg.Cfg_Req  = req_r;
  assign cfg.Cfg_Data = data_r;
  assign cfg.Cfg_Err  = err_r;
  assign Volume       = vol_r;
  assign Mute         = mute_r;
  assign Busy         = busy_r;

endmodule

// File: tb/tb_key_vol_ctrl.sv
// Directed bench for key_vol_ctrl with ACK_TIMEOUT=16 and GAP_CYC=4.
module tb_key_vol_ctrl;

  logic       Clk;
  logic       Reset;
  logic       Key_Up_Flag;
  logic       Key_Dn_Flag;
  logic       Key_Mute_Flag;
  logic [6:0] Volume;
  logic       Mute;
  logic       Busy;

  int total;
  int bad;
  int nreq;
  logic req_prev;

  key_vol_ctrl_if cfg_if ();

  key_vol_ctrl #(
    .ACK_TIMEOUT (16),
    .GAP_CYC     (4)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Key_Up_Flag   (Key_Up_Flag),
    .Key_Dn_Flag   (Key_Dn_Flag),
    .Key_Mute_Flag (Key_Mute_Flag),
    .cfg           (cfg_if),
    .Volume        (Volume),
    .Mute          (Mute),
    .Busy          (Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Counts rising edges of Cfg_Req, sampled on the inactive edge.
  always @(negedge Clk) begin
    if (cfg_if.Cfg_Req && !req_prev) nreq++;
    req_prev = cfg_if.Cfg_Req;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic up, input logic dn, input logic mu);
    Key_Up_Flag   = up;
    Key_Dn_Flag   = dn;
    Key_Mute_Flag = mu;
    step();
    Key_Up_Flag   = 1'b0;
    Key_Dn_Flag   = 1'b0;
    Key_Mute_Flag = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int n;
    n = 0;
    while (!cfg_if.Cfg_Req && n < max) begin
      step();
      n++;
    end
    chk("req_seen", 32'(cfg_if.Cfg_Req), 32'd1);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (Busy && n < max) begin
      step();
      n++;
    end
    chk("busy_clear", 32'(Busy), 32'd0);
  endtask

  // One key event answered by an immediate ack.
  task automatic do_key(input logic up, input logic dn, input logic mu,
                        input logic [31:0] exp_data, input string tag);
    pulse(up, dn, mu);
    wait_req(8);
    chk(tag, 32'(cfg_if.Cfg_Data), exp_data);
    cfg_if.Cfg_Ack = 1'b1;
    step();
    cfg_if.Cfg_Ack = 1'b0;
    chk("req_drop", 32'(cfg_if.Cfg_Req), 32'd0);
    wait_idle(10);
  endtask

  initial begin
    int v;
    int hi;
    int n;
    int base;
    logic done;
    total = 0;
    bad = 0;
    nreq = 0;
    req_prev = 1'b0;
    Reset = 1'b1;
    Key_Up_Flag = 1'b0;
    Key_Dn_Flag = 1'b0;
    Key_Mute_Flag = 1'b0;
    cfg_if.Cfg_Ack = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_req", 32'(cfg_if.Cfg_Req), 32'd0);
    chk("rst_data", 32'(cfg_if.Cfg_Data), 32'h0000);
    chk("rst_vol", 32'(Volume), 32'd121);
    chk("rst_mute", 32'(Mute), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_err", 32'(cfg_if.Cfg_Err), 32'd0);
    Reset = 1'b0;
    step();

    // Single up press, ack three cycles after request
    pulse(1'b1, 1'b0, 1'b0);
    chk("t1_req_lat1", 32'(cfg_if.Cfg_Req), 32'd0);
    step();
    chk("t1_req_rise", 32'(cfg_if.Cfg_Req), 32'd1);
    chk("t1_data", 32'(cfg_if.Cfg_Data), 32'h047D);
    chk("t1_vol", 32'(Volume), 32'd125);
    chk("t1_busy", 32'(Busy), 32'd1);
    step();
    step();
    chk("t1_req_hold", 32'(cfg_if.Cfg_Req), 32'd1);
    chk("t1_data_hold", 32'(cfg_if.Cfg_Data), 32'h047D);
    cfg_if.Cfg_Ack = 1'b1;
    step();
    cfg_if.Cfg_Ack = 1'b0;
    chk("t1_req_fall", 32'(cfg_if.Cfg_Req), 32'd0);
    chk("t1_busy_gap", 32'(Busy), 32'd1);
    step();
    step();
    step();
    chk("t1_busy_gap_end", 32'(Busy), 32'd1);
    step();
    chk("t1_busy_low", 32'(Busy), 32'd0);

    // Stray ack while idle is ignored
    cfg_if.Cfg_Ack = 1'b1;
    step();
    cfg_if.Cfg_Ack = 1'b0;
    step();
    chk("stray_ack_busy", 32'(Busy), 32'd0);
    chk("stray_ack_req", 32'(cfg_if.Cfg_Req), 32'd0);

    // Three ups from reset: saturate at 127
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    step();
    base = nreq;
    do_key(1'b1, 1'b0, 1'b0, 32'h047D, "t2_w1");
    do_key(1'b1, 1'b0, 1'b0, 32'h047F, "t2_w2");
    do_key(1'b1, 1'b0, 1'b0, 32'h047F, "t2_w3");
    chk("t2_vol", 32'(Volume), 32'd127);
    chk("t2_nreq", 32'(nreq - base), 32'd3);

    // Step down to the floor, then one more press at the floor
    v = 127;
    for (int i = 0; i < 20; i++) begin
      v = (v - 4 < 48) ? 48 : v - 4;
      do_key(1'b0, 1'b1, 1'b0, 32'h0400 + 32'(v), "t3_dn");
    end
    chk("t3_vol_floor", 32'(Volume), 32'd48);
    do_key(1'b0, 1'b1, 1'b0, 32'h0430, "t3_dn_sat");
    chk("t3_vol_sat", 32'(Volume), 32'd48);

    // Up+down cancel, then mute one cycle later
    base = nreq;
    pulse(1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("t4_no_req", 32'(cfg_if.Cfg_Req), 32'd0);
    chk("t4_idle", 32'(Busy), 32'd0);
    step();
    chk("t4_req", 32'(cfg_if.Cfg_Req), 32'd1);
    chk("t4_data", 32'(cfg_if.Cfg_Data), 32'h0A01);
    chk("t4_mute", 32'(Mute), 32'd1);
    chk("t4_vol", 32'(Volume), 32'd48);
    cfg_if.Cfg_Ack = 1'b1;
    step();
    cfg_if.Cfg_Ack = 1'b0;
    wait_idle(10);
    chk("t4_nreq", 32'(nreq - base), 32'd1);

    // No ack: timeout after 16 request cycles, then pending down is served
    pulse(1'b1, 1'b0, 1'b0);
    step();
    chk("t5_req", 32'(cfg_if.Cfg_Req), 32'd1);
    chk("t5_data", 32'(cfg_if.Cfg_Data), 32'h0434);
    pulse(1'b0, 1'b1, 1'b0);
    hi = 2;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      chk("t5_err_early", 32'(cfg_if.Cfg_Err), 32'd0);
      step();
      if (cfg_if.Cfg_Req) hi++;
      else done = 1'b1;
    end
    chk("t5_req_cycles", 32'(hi), 32'd16);
    chk("t5_err", 32'(cfg_if.Cfg_Err), 32'd1);
    chk("t5_vol_kept", 32'(Volume), 32'd52);
    step();
    chk("t5_err_pulse", 32'(cfg_if.Cfg_Err), 32'd0);
    chk("t5_busy_gap", 32'(Busy), 32'd1);
    n = 0;
    while (!cfg_if.Cfg_Req && n < 10) begin
      step();
      n++;
    end
    chk("t5_next_after_gap", 32'(n), 32'd4);
    chk("t5_next_data", 32'(cfg_if.Cfg_Data), 32'h0430);
    chk("t5_next_vol", 32'(Volume), 32'd48);

    // Reset during WAIT_ACK with a pending down
    pulse(1'b0, 1'b1, 1'b0);
    chk("t6_req_before", 32'(cfg_if.Cfg_Req), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    chk("t6_req_async", 32'(cfg_if.Cfg_Req), 32'd0);
    chk("t6_vol", 32'(Volume), 32'd121);
    chk("t6_mute", 32'(Mute), 32'd0);
    chk("t6_busy", 32'(Busy), 32'd0);
    chk("t6_data", 32'(cfg_if.Cfg_Data), 32'h0000);
    step();
    Reset = 1'b0;
    base = nreq;
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_req", 32'(nreq - base), 32'd0);
    chk("t6_idle", 32'(Busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_vol_ctrl.md
Name: key_vol_ctrl

Overview:
- Converts one-cycle debounced key flags (volume up, volume down, mute toggle) into audio-codec register writes.
- Holds the current volume and mute state, arbitrates pending key events, and sequences one 16-bit configuration word at a time to the codec config writer using a req/ack handshake.
- Sits between the per-key debounce blocks and the I2C codec configuration master in the I2S playback path.

Parameters:
- VOL_W, 7, width of the volume register.
- VOL_MAX, 127, upper saturation value of the volume.
- VOL_MIN, 48, lower saturation value of the volume.
- VOL_DEF, 121, volume value after reset.
- VOL_STEP, 4, increment/decrement applied per key event.
- VOL_ADDR, 7'h02, codec register address for volume writes.
- MUTE_ADDR, 7'h05, codec register address for mute writes.
- ACK_TIMEOUT, 1000000, maximum cycles to wait for Cfg_Ack.
- GAP_CYC, 1000, idle cycles enforced after each completed or aborted write.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous reset, active-high
- Key_Up_Flag  in  1  one-cycle volume-up pulse
- Key_Dn_Flag  in  1  one-cycle volume-down pulse
- Key_Mute_Flag  in  1  one-cycle mute-toggle pulse
- Cfg_Ack  in  1  one-cycle write-complete pulse from the config master
- Cfg_Req  out  1  write request, level
- Cfg_Data  out  16  {addr[6:0], data[8:0]}
- Volume  out  VOL_W  current volume
- Mute  out  1  current mute state
- Busy  out  1  high in any state other than IDLE
- Cfg_Err  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset values: Cfg_Req=0, Cfg_Data=0, Volume=VOL_DEF, Mute=0, Busy=0, Cfg_Err=0, all pending bits=0, state=IDLE, counters=0.
- Pending latches:
  - pend_up, pend_dn and pend_mute are each set on their flag.
  - A flag arriving in the same cycle as its own clear leaves the bit set.
  - Repeated flags while a bit is already set coalesce into a single event.
- States: IDLE, WAIT_ACK, GAP.
- IDLE: evaluated each cycle on the registered pending bits. Priority is mute > (up and down together) > up > down.
  - pend_mute: toggle Mute; Cfg_Data={MUTE_ADDR, 8'b0, new Mute}; clear pend_mute; Cfg_Req<=1; go to WAIT_ACK.
  - pend_up and pend_dn both set: clear both; no write; stay in IDLE.
  - pend_up: Volume<=min(Volume+VOL_STEP, VOL_MAX); Cfg_Data={VOL_ADDR, 2'b0, new Volume}, zero-extended to 9 bits; clear pend_up; Cfg_Req<=1; go to WAIT_ACK.
  - pend_dn: Volume<=max(Volume-VOL_STEP, VOL_MIN); write and transition as for pend_up.
  - Saturation arithmetic is done at VOL_W+1 bits, so no wrap-around.
  - A write is issued even when Volume is already saturated, i.e. the value is unchanged.
- Latency: a flag at cycle t sets pending at t+1; Cfg_Req is high from t+2 when IDLE.
- WAIT_ACK:
  - Cfg_Req and Cfg_Data stay stable.
  - Cfg_Ack=1: Cfg_Req<=0, go to GAP.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT-1: Cfg_Req<=0, Cfg_Err=1 for one cycle, go to GAP.
  - On timeout, Volume/Mute keep their updated values.
- GAP: count GAP_CYC cycles, then return to IDLE. Pending bits keep accumulating during WAIT_ACK and GAP.
- Cfg_Ack outside WAIT_ACK is ignored.
- Counters clear on every state entry.
- Reset asserted mid-transaction returns all state to reset values immediately. Cfg_Req drops asynchronously and the pending transaction is lost.

Test Plan (ACK_TIMEOUT=16, GAP_CYC=4):
- Key_Up_Flag pulse after reset; ack 3 cycles after Cfg_Req rises -> Cfg_Req rises 2 cycles after the flag; Cfg_Data=16'h047D (Volume=125); Req falls the cycle after ack; Busy high until 4 GAP cycles elapse.
- Three Key_Up_Flag pulses with immediate acks -> writes of 125, 127, 127; Volume saturates at 127; three requests issued.
- Key_Dn_Flag pulse while Volume=48 -> Volume stays 48; Cfg_Data=16'h0430.
- Key_Up_Flag and Key_Dn_Flag in the same cycle, Key_Mute_Flag one cycle later -> no volume write; a single mute write Cfg_Data=16'h0A01; Mute=1.
- No ack given -> Cfg_Req held for 16 cycles, then drops; Cfg_Err pulses once; Volume keeps its new value; next pending event is served after GAP.
- Reset asserted during WAIT_ACK with pend_dn set -> Cfg_Req=0 the same cycle; Volume=121; Mute=0; no request after reset releases.
